// File: rtl/huffman_table_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : huffman_table_loader_if
// Description : UART-side, table-write and control signals of the loader.
// Revision    : 1.0  initial release
// ============================================================================
interface huffman_table_loader_if #(
    parameter int MAX_LEN = 12,
    parameter int DEPTH   = 256,
    parameter int LEN_W   = 4
);
    logic [7:0]                 rx_data;
    logic                       data_ready;
    logic                       overrun_error;
    logic                       framing_error;
    logic                       data_read;
    logic                       wr_en;
    logic [$clog2(DEPTH)-1:0]   wr_addr;
    logic [7:0]                 wr_sym;
    logic [LEN_W-1:0]           wr_len;
    logic [MAX_LEN-1:0]         wr_path;
    logic                       wr_ack;
    logic                       decode_done;
    logic                       err_clr;
    logic                       lookup_done;
    logic [$clog2(DEPTH+1)-1:0] entry_count;
    logic                       load_error;
    logic [1:0]                 error_code;

    modport master (
        input  rx_data, data_ready, overrun_error, framing_error,
        input  wr_ack, decode_done, err_clr,
        output data_read, wr_en, wr_addr, wr_sym, wr_len, wr_path,
        output lookup_done, entry_count, load_error, error_code
    );

    modport slave (
        output rx_data, data_ready, overrun_error, framing_error,
        output wr_ack, decode_done, err_clr,
        input  data_read, wr_en, wr_addr, wr_sym, wr_len, wr_path,
        input  lookup_done, entry_count, load_error, error_code
    );
endinterface
`default_nettype wire

// File: rtl/huffman_table_loader.sv
`default_nettype none
// ============================================================================
// Module      : huffman_table_loader
// Description : Parses {symbol, length, path bytes} records from a UART byte
//               stream and writes them into the code-table register block.
// Revision    : 1.0  initial release
// ============================================================================
module huffman_table_loader #(
    parameter int MAX_LEN = 12,
    parameter int DEPTH   = 256,
    parameter int LEN_W   = 4
) (
    input  wire logic             clk,
    input  wire logic             n_rst,
    huffman_table_loader_if.master bus
);
    localparam int PATH_BYTES = (MAX_LEN + 7) / 8;
    localparam int IDX_W      = (PATH_BYTES > 1) ? $clog2(PATH_BYTES) : 1;
    localparam int ADDR_W     = $clog2(DEPTH);
    localparam int CNT_W      = $clog2(DEPTH + 1);

    localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PATH_BYTES - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LINE = 2'd1;
    localparam logic [1:0] ERR_LEN  = 2'd2;
    localparam logic [1:0] ERR_FULL = 2'd3;

    typedef enum logic [2:0] {
        S_GET_SYM  = 3'd0,
        S_GET_LEN  = 3'd1,
        S_GET_PATH = 3'd2,
        S_WRITE    = 3'd3,
        S_DONE     = 3'd4,
        S_ERROR    = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         sym_q, sym_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [MAX_LEN-1:0] path_q, path_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [1:0]         err_q, err_d;
    logic               wr_en_q;
    logic               done_q;
    logic               lerr_q;

    logic w_parsing;
    logic w_consume;
    logic w_line_err;

    assign w_parsing  = (state_q == S_GET_SYM) || (state_q == S_GET_LEN) ||
                        (state_q == S_GET_PATH);
    assign w_consume  = w_parsing && bus.data_ready;
    assign w_line_err = bus.overrun_error || bus.framing_error;

    always_comb begin
        state_d = state_q;
        sym_d   = sym_q;
        len_d   = len_q;
        path_d  = path_q;
        idx_d   = idx_q;
        count_d = count_q;
        err_d   = err_q;
        case (state_q)
            S_GET_SYM: begin
                if (w_consume) begin
                    if (w_line_err) begin
                        state_d = S_ERROR;
                        err_d   = ERR_LINE;
                    end else begin
                        sym_d   = bus.rx_data;
                        state_d = S_GET_LEN;
                    end
                end
            end
            S_GET_LEN: begin
                if (w_consume) begin
                    if (w_line_err) begin
                        state_d = S_ERROR;
                        err_d   = ERR_LINE;
                    end else if (bus.rx_data == 8'd0) begin
                        state_d = S_DONE;
                    end else if (bus.rx_data > MAX_LEN_B) begin
                        state_d = S_ERROR;
                        err_d   = ERR_LEN;
                    end else if (count_q == FULL_CNT) begin
                        state_d = S_ERROR;
                        err_d   = ERR_FULL;
                    end else begin
                        len_d   = bus.rx_data[LEN_W-1:0];
                        path_d  = '0;
                        idx_d   = '0;
                        state_d = S_GET_PATH;
                    end
                end
            end
            S_GET_PATH: begin
                if (w_consume) begin
                    if (w_line_err) begin
                        state_d = S_ERROR;
                        err_d   = ERR_LINE;
                    end else begin
                        // Shifting in MAX_LEN width drops path bits beyond the code length limit.
                        path_d = path_q | (MAX_LEN'(bus.rx_data) << {idx_q, 3'b000});
                        if (idx_q == LAST_IDX) begin
                            state_d = S_WRITE;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
            end
            S_WRITE: begin
                if (bus.wr_ack) begin
                    count_d = count_q + CNT_W'(1);
                    state_d = S_GET_SYM;
                end
            end
            S_DONE: begin
                if (bus.decode_done) begin
                    count_d = '0;
                    state_d = S_GET_SYM;
                end
            end
            S_ERROR: begin
                if (bus.err_clr) begin
                    count_d = '0;
                    err_d   = ERR_NONE;
                    state_d = S_GET_SYM;
                end
            end
            default: state_d = S_GET_SYM;
        endcase
    end

    // Status flags are registered from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= S_GET_SYM;
            sym_q   <= '0;
            len_q   <= '0;
            path_q  <= '0;
            idx_q   <= '0;
            count_q <= '0;
            err_q   <= ERR_NONE;
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            lerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sym_q   <= sym_d;
            len_q   <= len_d;
            path_q  <= path_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            err_q   <= err_d;
            wr_en_q <= (state_d == S_WRITE);
            done_q  <= (state_d == S_DONE);
            lerr_q  <= (state_d == S_ERROR);
        end
    end

    assign bus.data_read   = w_consume;
    assign bus.wr_en       = wr_en_q;
    assign bus.wr_addr     = count_q[ADDR_W-1:0];
    assign bus.wr_sym      = sym_q;
    assign bus.wr_len      = len_q;
    assign bus.wr_path     = path_q;
    assign bus.lookup_done = done_q;
    assign bus.entry_count = count_q;
    assign bus.load_error  = lerr_q;
    assign bus.error_code  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_huffman_table_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_huffman_table_loader
// Description : Directed bench with a write scoreboard for huffman_table_loader.
// Revision    : 1.0  initial release
// ============================================================================
module tb_huffman_table_loader;
    logic clk = 1'b0;
    logic n_rst;

    huffman_table_loader_if #(.MAX_LEN(12), .DEPTH(4), .LEN_W(4)) bus ();

    huffman_table_loader #(.MAX_LEN(12), .DEPTH(4), .LEN_W(4)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  addr;
        logic [7:0]  sym;
        logic [3:0]  len;
        logic [11:0] path;
    } wr_t;

    wr_t exp_q[$];
    int  checks     = 0;
    int  errors     = 0;
    int  wr_seen    = 0;
    int  exp_writes = 0;
    int  exp_cnt    = 0;

    always @(posedge clk) begin
        if (bus.wr_en && bus.wr_ack) wr_seen <= wr_seen + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bound_fail(input string tag);
        checks++;
        errors++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic fe = 1'b0);
        int n;
        bus.rx_data       = b;
        bus.framing_error = fe;
        bus.data_ready    = 1'b1;
        #1;
        n = 0;
        while (!bus.data_read && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.data_read) bound_fail("data_read");
        @(negedge clk);
        bus.data_ready    = 1'b0;
        bus.framing_error = 1'b0;
        bus.rx_data       = 8'h00;
    endtask

    task automatic send_rec(input logic [7:0] sym, input logic [7:0] len,
                            input logic [7:0] b0, input logic [7:0] b1);
        wr_t         e;
        logic [15:0] raw;
        raw    = {b1, b0};
        e.addr = exp_cnt[1:0];
        e.sym  = sym;
        e.len  = len[3:0];
        e.path = raw[11:0];
        exp_q.push_back(e);
        send_byte(sym);
        send_byte(len);
        send_byte(b0);
        send_byte(b1);
    endtask

    task automatic check_write(input int delay);
        wr_t e;
        int  n;
        n = 0;
        while (!bus.wr_en && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.wr_en) begin
            bound_fail("wr_en");
            return;
        end
        if (exp_q.size() == 0) begin
            bound_fail("scoreboard_empty");
            return;
        end
        e = exp_q.pop_front();
        chk("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
        chk("wr_sym",  32'(bus.wr_sym),  32'(e.sym));
        chk("wr_len",  32'(bus.wr_len),  32'(e.len));
        chk("wr_path", 32'(bus.wr_path), 32'(e.path));
        n = 1;
        bus.rx_data    = 8'hA5;
        bus.data_ready = 1'b1;
        for (int i = 0; i < delay; i++) begin
            #1;
            chk("read_while_write", 32'(bus.data_read), 32'd0);
            @(negedge clk);
            if (bus.wr_en) n++;
            chk("fields_stable", {bus.wr_addr, bus.wr_sym, bus.wr_len, bus.wr_path}, 32'(e));
        end
        bus.data_ready = 1'b0;
        bus.wr_ack     = 1'b1;
        @(negedge clk);
        bus.wr_ack = 1'b0;
        chk("wr_en_cycles", n, delay + 1);
        chk("wr_en_drop", 32'(bus.wr_en), 32'd0);
        exp_cnt++;
        exp_writes++;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wr_en"},  32'(bus.wr_en), 32'd0);
        chk({tag, "_fields"}, {bus.wr_addr, bus.wr_sym, bus.wr_len, bus.wr_path}, 32'd0);
        chk({tag, "_status"}, {bus.lookup_done, bus.load_error, bus.error_code, bus.data_read}, 32'd0);
        chk({tag, "_count"},  32'(bus.entry_count), 32'd0);
    endtask

    task automatic pulse_err_clr();
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        exp_cnt     = 0;
        chk("err_cleared", {bus.load_error, bus.error_code}, 32'd0);
        chk("err_clr_count", 32'(bus.entry_count), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst             = 1'b0;
        bus.rx_data       = 8'h00;
        bus.data_ready    = 1'b0;
        bus.overrun_error = 1'b0;
        bus.framing_error = 1'b0;
        bus.wr_ack        = 1'b0;
        bus.decode_done   = 1'b0;
        bus.err_clr       = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        n_rst = 1'b1;
        @(negedge clk);

        // 1: single entry, immediate ack, end marker, decoder release
        send_rec(8'h41, 8'h03, 8'h05, 8'h00);
        check_write(0);
        send_byte(8'h00);
        send_byte(8'h00);
        chk("lookup_done", 32'(bus.lookup_done), 32'd1);
        chk("done_count", 32'(bus.entry_count), 32'd1);
        bus.data_ready = 1'b1;
        #1;
        chk("done_no_read", 32'(bus.data_read), 32'd0);
        bus.data_ready  = 1'b0;
        bus.decode_done = 1'b1;
        @(negedge clk);
        bus.decode_done = 1'b0;
        exp_cnt         = 0;
        chk("decode_release", {bus.lookup_done, bus.entry_count}, 32'd0);
        bus.data_ready = 1'b1;
        #1;
        chk("back_to_get_sym", 32'(bus.data_read), 32'd1);
        bus.data_ready = 1'b0;
        @(negedge clk);

        // 2: delayed ack, full-length code with bits above MAX_LEN dropped
        send_rec(8'h7A, 8'h0C, 8'hFF, 8'hFF);
        check_write(5);
        chk("count_after_delay", 32'(bus.entry_count), 32'd1);

        // 3: over-length code
        send_byte(8'h10);
        send_byte(8'h0D);
        chk("len_err", {bus.load_error, bus.error_code}, 32'h6);
        chk("len_err_no_write", wr_seen, exp_writes);
        pulse_err_clr();
        send_rec(8'h22, 8'h01, 8'h01, 8'h00);
        check_write(0);

        // 4: framing error on second path byte
        send_byte(8'h33);
        send_byte(8'h04);
        send_byte(8'h0A);
        send_byte(8'hBB, 1'b1);
        chk("line_err", {bus.load_error, bus.error_code}, 32'h5);
        chk("line_err_count", 32'(bus.entry_count), 32'd1);
        chk("line_err_no_write", wr_seen, exp_writes);
        pulse_err_clr();

        // 5: table full at DEPTH entries
        for (int i = 0; i < 4; i++) begin
            send_rec(8'(8'h80 + i), 8'(i + 1), 8'(i * 3 + 1), 8'h00);
            check_write(0);
        end
        chk("full_count", 32'(bus.entry_count), 32'd4);
        send_byte(8'h90);
        send_byte(8'h05);
        chk("full_err", {bus.load_error, bus.error_code}, 32'h7);
        chk("full_no_write", wr_seen, exp_writes);
        pulse_err_clr();

        // 6: reset in the middle of a path
        send_rec(8'h60, 8'h02, 8'h03, 8'h00);
        check_write(0);
        send_byte(8'h55);
        send_byte(8'h06);
        send_byte(8'h12);
        n_rst = 1'b0;
        @(negedge clk);
        chk_zero("midreset");
        n_rst   = 1'b1;
        exp_cnt = 0;
        @(negedge clk);
        send_rec(8'h66, 8'h07, 8'h40, 8'h00);
        check_write(0);
        chk("post_reset_count", 32'(bus.entry_count), 32'd1);

        chk("write_total", wr_seen, exp_writes);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
